// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, funct codes, ALU operations and decoded control bundle for simple_mips
package mips_pkg;
  localparam int RF_DEPTH  = 32;
  localparam int MEM_DEPTH = 1024;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
                         OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f,
                         OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08,
                         FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
  typedef struct packed {
    logic    reg_we;
    logic    mem_we;
    logic    mem_to_reg;
    logic    alu_imm;
    logic    zext;
    logic    branch;
    logic    bne;
    logic    jump;
    logic    jr;
    logic    link;
    logic    rtype;
    alu_op_t alu_op;
  } ctrl_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit ALU; shifts take their amount from the instruction shamt field
module alu import mips_pkg::*; (
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sh,
  output logic [31:0] y
);
  always_comb
    case (op)
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_NOR:  y = ~(a | b);
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_SLL:  y = b << sh;
      ALU_SRL:  y = b >> sh;
      ALU_SRA:  y = $signed(b) >>> sh;
      ALU_LUI:  y = {b[15:0], 16'h0};
      default:  y = a + b;
    endcase
endmodule

// File: rtl/control.sv
// control: decodes opcode/funct into the datapath control bundle; unknown encodings become nops
module control import mips_pkg::*; (
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output ctrl_t      c
);
  always_comb begin
    c = '0;
    c.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        c.rtype  = 1'b1;
        c.reg_we = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:          c.alu_op = ALU_AND;
          FN_OR:           c.alu_op = ALU_OR;
          FN_XOR:          c.alu_op = ALU_XOR;
          FN_NOR:          c.alu_op = ALU_NOR;
          FN_SLT:          c.alu_op = ALU_SLT;
          FN_SLTU:         c.alu_op = ALU_SLTU;
          FN_SLL:          c.alu_op = ALU_SLL;
          FN_SRL:          c.alu_op = ALU_SRL;
          FN_SRA:          c.alu_op = ALU_SRA;
          FN_JR:           {c.reg_we, c.jr} = 2'b01;
          default:         c.reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: {c.reg_we, c.alu_imm} = 2'b11;
      OP_SLTI: begin
        {c.reg_we, c.alu_imm} = 2'b11;
        c.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        {c.reg_we, c.alu_imm, c.zext} = 3'b111;
        c.alu_op = ALU_AND;
      end
      OP_ORI: begin
        {c.reg_we, c.alu_imm, c.zext} = 3'b111;
        c.alu_op = ALU_OR;
      end
      OP_XORI: begin
        {c.reg_we, c.alu_imm, c.zext} = 3'b111;
        c.alu_op = ALU_XOR;
      end
      OP_LUI: begin
        {c.reg_we, c.alu_imm} = 2'b11;
        c.alu_op = ALU_LUI;
      end
      OP_LW:  {c.reg_we, c.alu_imm, c.mem_to_reg} = 3'b111;
      OP_SW:  {c.mem_we, c.alu_imm} = 2'b11;
      OP_BEQ: c.branch = 1'b1;
      OP_BNE: {c.branch, c.bne} = 2'b11;
      OP_J:   c.jump = 1'b1;
      OP_JAL: {c.jump, c.link, c.reg_we} = 3'b111;
      default: ;
    endcase
  end
endmodule

// File: rtl/dm.sv
// dm: 1024-word data memory, combinational read, write on the rising edge, never reset
module dm import mips_pkg::*; (
  input  logic        clk,
  input  logic        we,
  input  logic [9:0]  idx,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] mem [0:MEM_DEPTH-1];
  assign rd = mem[idx];
  always_ff @(posedge clk) if (we) mem[idx] <= wd;
endmodule

// File: rtl/fetch.sv
// fetch: PC register, next-PC selection and instruction memory
module fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        jr,
  input  logic        jump,
  input  logic        take,
  input  logic [31:0] rs_val,
  output logic [31:0] instr,
  output logic [31:0] pc4
);
  logic [31:0] pc_w = '0;
  logic [31:0] npc;
  assign pc4 = pc_w + 32'd4;
  assign npc = jr   ? rs_val :
               jump ? {pc4[31:28], instr[25:0], 2'b00} :
               take ? pc4 + {{14{instr[15]}}, instr[15:0], 2'b00} : pc4;
  always_ff @(posedge clk) pc_w <= rst ? '0 : npc;
  im U_IM (.idx(pc_w[11:2]), .instr(instr));
endmodule

// File: rtl/im.sv
// im: instruction memory, combinational word read, contents preloaded externally
module im import mips_pkg::*; (
  input  logic [9:0]  idx,
  output logic [31:0] instr
);
  logic [31:0] instr_mem [0:MEM_DEPTH-1] = '{default: '0};
  assign instr = instr_mem[idx];
endmodule

// File: rtl/regfile.sv
// regfile: 32x32 register file, two combinational reads, one write port, $0 hardwired to zero
module regfile import mips_pkg::*; (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rda,
  output logic [31:0] rdb
);
  logic [31:0] regs [0:RF_DEPTH-1] = '{default: '0};
  assign rda = ra == 5'd0 ? '0 : regs[ra];
  assign rdb = rb == 5'd0 ? '0 : regs[rb];
  always_ff @(posedge clk) if (we && wa != 5'd0) regs[wa] <= wd;
endmodule

// File: rtl/simple_mips.sv
// simple_mips: single-cycle MIPS-I subset core, one instruction retired per rising edge
module simple_mips import mips_pkg::*; (
  input logic clk,
  input logic rst
);
  logic [31:0] instr, pc4, rs_val, rt_val, imm, alu_b, alu_y, mem_rd, wd;
  logic [4:0]  wa;
  ctrl_t       c;
  fetch U_fetch (
    .clk(clk), .rst(rst), .jr(c.jr), .jump(c.jump),
    .take(c.branch & ((rs_val == rt_val) ^ c.bne)),
    .rs_val(rs_val), .instr(instr), .pc4(pc4)
  );
  control U_ctrl (.op(instr[31:26]), .fn(instr[5:0]), .c(c));
  regfile U_rf (
    .clk(clk), .we(c.reg_we & ~rst), .ra(instr[25:21]), .rb(instr[20:16]),
    .wa(wa), .wd(wd), .rda(rs_val), .rdb(rt_val)
  );
  assign imm   = c.zext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
  assign alu_b = c.alu_imm ? imm : rt_val;
  alu U_alu (.op(c.alu_op), .a(rs_val), .b(alu_b), .sh(instr[10:6]), .y(alu_y));
  dm U_dm (.clk(clk), .we(c.mem_we & ~rst), .idx(alu_y[11:2]), .wd(rt_val), .rd(mem_rd));
  assign wa = c.link ? 5'd31 : c.rtype ? instr[15:11] : instr[20:16];
  assign wd = c.link ? pc4 : c.mem_to_reg ? mem_rd : alu_y;
endmodule

// File: tb/tb_simple_mips.sv
// tb_simple_mips: directed programs plus random programs checked against an instruction-level model
module tb_simple_mips;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [1024];
  logic [31:0] m_im [1024];

  simple_mips dut (.clk(clk), .rst(rst));

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic write_im(input int idx, input logic [31:0] w);
    m_im[idx] = w;
    dut.U_fetch.U_IM.instr_mem[idx] = w;
  endtask

  task automatic clear_im();
    for (int k = 0; k < 1024; k++) write_im(k, 32'h0);
  endtask

  // Architectural effect of one instruction, straight from the ISA rules.
  task automatic model_step();
    logic [31:0] i, a, b, se, ea, nxt, wv;
    int wr;
    i   = m_im[m_pc[11:2]];
    a   = m_rf[i[25:21]];
    b   = m_rf[i[20:16]];
    se  = {{16{i[15]}}, i[15:0]};
    ea  = a + se;
    nxt = m_pc + 32'd4;
    wr  = 0;
    wv  = '0;
    case (i[31:26])
      6'h00: begin
        wr = int'(i[15:11]);
        case (i[5:0])
          6'h20, 6'h21: wv = a + b;
          6'h22, 6'h23: wv = a - b;
          6'h24: wv = a & b;
          6'h25: wv = a | b;
          6'h26: wv = a ^ b;
          6'h27: wv = ~(a | b);
          6'h2a: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: wv = (a < b) ? 32'd1 : 32'd0;
          6'h00: wv = b << i[10:6];
          6'h02: wv = b >> i[10:6];
          6'h03: wv = $signed(b) >>> i[10:6];
          6'h08: begin wr = 0; nxt = a; end
          default: wr = 0;
        endcase
      end
      6'h08, 6'h09: begin wr = int'(i[20:16]); wv = ea; end
      6'h0a: begin wr = int'(i[20:16]); wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0c: begin wr = int'(i[20:16]); wv = a & {16'h0, i[15:0]}; end
      6'h0d: begin wr = int'(i[20:16]); wv = a | {16'h0, i[15:0]}; end
      6'h0e: begin wr = int'(i[20:16]); wv = a ^ {16'h0, i[15:0]}; end
      6'h0f: begin wr = int'(i[20:16]); wv = {i[15:0], 16'h0}; end
      6'h23: begin wr = int'(i[20:16]); wv = m_dm[ea[11:2]]; end
      6'h2b: m_dm[ea[11:2]] = b;
      6'h04: if (a == b) nxt = nxt + (se << 2);
      6'h05: if (a != b) nxt = nxt + (se << 2);
      6'h02: nxt = {nxt[31:28], i[25:0], 2'b00};
      6'h03: begin wr = 31; wv = nxt; nxt = {nxt[31:28], i[25:0], 2'b00}; end
      default: ;
    endcase
    if (wr != 0) m_rf[wr] = wv;
    m_pc = nxt;
  endtask

  task automatic tick();
    if (rst) m_pc = '0;
    else model_step();
    @(posedge clk);
    #1;
    chk("pc", dut.U_fetch.pc_w, m_pc);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_regs();
    for (int k = 0; k < 32; k++) chk($sformatf("r%0d", k), dut.U_rf.regs[k], k == 0 ? 32'h0 : m_rf[k]);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fns [15] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h01};
    logic [5:0] ops [14] = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                             6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
    logic [4:0] rs, rt, rd;
    logic [5:0] op;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    if ($urandom_range(0, 3) == 0) return enc_r(rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 14)]);
    op = ops[$urandom_range(0, 13)];
    if (op == 6'h02 || op == 6'h03) return {op, 26'($urandom)};
    if (op == 6'h04 || op == 6'h05) imm = 16'($urandom_range(0, 15)) - 16'd8;
    return enc_i(op, rs, rt, imm);
  endfunction

  initial begin
    for (int k = 0; k < 32; k++) m_rf[k] = '0;
    for (int k = 0; k < 1024; k++) m_dm[k] = 'x;
    #10;
    // Self-loop: beq with offset -1 stays at 0x4 forever.
    clear_im();
    write_im(0, 32'hafa6fffc);
    write_im(1, 32'h1064ffff);
    restart();
    run(100);
    chk("loop_pc", dut.U_fetch.pc_w, 32'h4);
    chk("loop_npc", dut.U_fetch.npc, 32'h4);
    chk("loop_instr", dut.U_fetch.instr, 32'h1064ffff);
    // Arithmetic and immediates.
    clear_im();
    write_im(0, enc_i(6'h09, 0, 1, 16'd5));
    write_im(1, enc_i(6'h09, 0, 2, 16'hfffd));
    write_im(2, enc_r(1, 2, 3, 0, 6'h21));
    write_im(3, enc_r(2, 1, 4, 0, 6'h2a));
    write_im(4, enc_i(6'h0f, 0, 5, 16'h1234));
    write_im(5, enc_i(6'h0d, 5, 5, 16'h5678));
    restart();
    run(6);
    chk("addu_r3", dut.U_rf.regs[3], 32'd2);
    chk("slt_r4", dut.U_rf.regs[4], 32'd1);
    chk("lui_ori_r5", dut.U_rf.regs[5], 32'h12345678);
    // Store then load through the same base register.
    clear_im();
    write_im(0, enc_i(6'h09, 0, 1, 16'h10));
    write_im(1, enc_i(6'h2b, 1, 1, 16'd4));
    write_im(2, enc_i(6'h23, 1, 2, 16'd4));
    restart();
    run(3);
    chk("sw_dm5", dut.U_dm.mem[5], 32'h10);
    chk("lw_r2", dut.U_rf.regs[2], 32'h10);
    // jal / jr / bne not taken / beq taken / j.
    clear_im();
    write_im(0, {6'h03, 26'h8});
    write_im(8, enc_r(31, 0, 0, 0, 6'h08));
    write_im(1, enc_i(6'h05, 0, 0, 16'h0010));
    write_im(2, enc_i(6'h04, 0, 0, 16'd3));
    write_im(6, {6'h02, 26'h0});
    restart();
    tick();
    chk("jal_pc", dut.U_fetch.pc_w, 32'h20);
    chk("jal_r31", dut.U_rf.regs[31], 32'h4);
    tick();
    chk("jr_pc", dut.U_fetch.pc_w, 32'h4);
    tick();
    chk("bne_nt_pc", dut.U_fetch.pc_w, 32'h8);
    tick();
    chk("beq_t_pc", dut.U_fetch.pc_w, 32'h18);
    tick();
    chk("j_pc", dut.U_fetch.pc_w, 32'h0);
    // $0 ignores writes and reads as zero.
    clear_im();
    write_im(0, enc_i(6'h09, 0, 0, 16'd7));
    write_im(1, enc_i(6'h09, 0, 6, 16'd1));
    restart();
    run(2);
    chk("r0_stored", dut.U_rf.regs[0], 32'h0);
    chk("r0_read_r6", dut.U_rf.regs[6], 32'h1);
    // Reset after five instructions suppresses the sixth write.
    clear_im();
    for (int k = 0; k < 8; k++) write_im(k, enc_i(6'h09, 0, 5'(10 + k), 16'(10 + k)));
    restart();
    run(5);
    chk("pre_rst_r14", dut.U_rf.regs[14], 32'd14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_pc", dut.U_fetch.pc_w, 32'h0);
    chk("rst_no_write_r15", dut.U_rf.regs[15], 32'h0);
    tick();
    chk("post_rst_pc", dut.U_fetch.pc_w, 32'h4);
    chk("post_rst_r10", dut.U_rf.regs[10], 32'd10);
    chk_regs();
    // Random programs with occasional resets.
    for (int k = 0; k < 1024; k++) begin
      write_im(k, rnd_instr());
      m_dm[k] = $urandom;
      dut.U_dm.mem[k] = m_dm[k];
    end
    restart();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      tick();
      if (n % 16 == 15) chk_regs();
    end
    rst = 1'b0;
    chk_regs();
    for (int k = 0; k < 1024; k++) chk($sformatf("dm%0d", k), dut.U_dm.mem[k], m_dm[k]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
